// File: rtl/reg_mst_arbiter.sv
// reg_mst_arbiter
//   Shares one register-slave FSM port between N_MST register masters.
//   Round-robin arbitration; the grant is held until the downstream FSM acks.
//   Ack, read data and error are routed back to the granted master only.
//   A watchdog aborts a transaction that stays BUSY for TIMEOUT_CYCLES cycles,
//   returning ERR_DATA with an error pulse and soft-resetting the FSM.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   mst__arb__*             per-master request side (packed, master i at slice i)
//   arb__mst__ack_vld/err   one-hot ack / error pulse to the granted master
//   arb__mst__rd_data       read data, non-zero only in an ack or error cycle
//   mst__arb__sync_reset    soft reset (drops any outstanding transaction)
//   arb__fsm__*             downstream request, payload latched for all of BUSY
//   fsm__arb__ack_vld/rd_data  downstream completion
//   arb__fsm__sync_reset    soft reset to the FSM (soft reset input or timeout)
//   arb__grant              current / last granted master index

// Per-master return path: decodes the grant index into this master's pulses.
module reg_mst_arb_lane #(
  parameter int unsigned IDX = 0,
  parameter int unsigned GW  = 1
) (
  input  logic [GW-1:0] grant,
  input  logic          ack_hit,
  input  logic          tmo_hit,
  output logic          ack_vld,
  output logic          err
);
  logic sel;
  assign sel     = (grant == GW'(IDX));
  assign ack_vld = sel & (ack_hit | tmo_hit);
  assign err     = sel & tmo_hit;
endmodule

module reg_mst_arbiter #(
  parameter int unsigned          N_MST          = 2,
  parameter int unsigned          ADDR_WIDTH     = 64,
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA      = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_MST-1:0]              mst__arb__req_vld,
  input  logic [N_MST*ADDR_WIDTH-1:0]   mst__arb__addr,
  input  logic [N_MST-1:0]              mst__arb__wr_en,
  input  logic [N_MST-1:0]              mst__arb__rd_en,
  input  logic [N_MST*DATA_WIDTH-1:0]   mst__arb__wr_data,
  output logic [N_MST-1:0]              arb__mst__ack_vld,
  output logic [DATA_WIDTH-1:0]         arb__mst__rd_data,
  output logic [N_MST-1:0]              arb__mst__err,
  input  logic                          mst__arb__sync_reset,
  output logic                          arb__fsm__req_vld,
  output logic [ADDR_WIDTH-1:0]         arb__fsm__addr,
  output logic                          arb__fsm__wr_en,
  output logic                          arb__fsm__rd_en,
  output logic [DATA_WIDTH-1:0]         arb__fsm__wr_data,
  input  logic                          fsm__arb__ack_vld,
  input  logic [DATA_WIDTH-1:0]         fsm__arb__rd_data,
  output logic                          arb__fsm__sync_reset,
  output logic [$clog2(N_MST)-1:0]      arb__grant
);
  localparam int unsigned GW = $clog2(N_MST);
  localparam int unsigned IW = GW + 1;  // room for rr_ptr + offset before wrap
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES > 0);
  // Counter holds 0 in the first BUSY cycle, so the Nth BUSY cycle sees N-1.
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] nxt_ptr;
  logic [CW-1:0] tmo_cnt;
  logic          busy;
  logic          ack_hit;
  logic          tmo_hit;

  assign busy = (state == BUSY);

  // Soft reset drops the transaction, so it also suppresses ack and timeout.
  assign ack_hit = busy & fsm__arb__ack_vld & ~mst__arb__sync_reset;
  assign tmo_hit = TMO_EN & busy & ~fsm__arb__ack_vld & ~mst__arb__sync_reset
                 & (tmo_cnt == TMO_LAST);

  // Round-robin pick: walk offsets high to low so the smallest offset from
  // rr_ptr with a request set is the final assignment.
  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    win = rr_ptr;
    for (int k = N_MST - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(N_MST)) idx = idx - IW'(N_MST);
      if (mst__arb__req_vld[idx[GW-1:0]]) win = idx[GW-1:0];
    end
  end

  assign nxt_ptr = (arb__grant == GW'(N_MST - 1)) ? '0 : arb__grant + 1'b1;

  always_comb begin
    arb__mst__rd_data = '0;
    if (ack_hit)      arb__mst__rd_data = fsm__arb__rd_data;
    else if (tmo_hit) arb__mst__rd_data = ERR_DATA;
  end

  assign arb__fsm__sync_reset = mst__arb__sync_reset | tmo_hit;

  for (genvar i = 0; i < N_MST; i++) begin : g_lane
    reg_mst_arb_lane #(.IDX(i), .GW(GW)) u_lane (
      .grant   (arb__grant),
      .ack_hit (ack_hit),
      .tmo_hit (tmo_hit),
      .ack_vld (arb__mst__ack_vld[i]),
      .err     (arb__mst__err[i])
    );
  end

  // Payload registers double as the downstream outputs: loaded on grant,
  // cleared on the way back to IDLE so they read 0 whenever not BUSY.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      arb__grant        <= '0;
      tmo_cnt           <= '0;
      arb__fsm__req_vld <= 1'b0;
      arb__fsm__addr    <= '0;
      arb__fsm__wr_en   <= 1'b0;
      arb__fsm__rd_en   <= 1'b0;
      arb__fsm__wr_data <= '0;
    end else if (mst__arb__sync_reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      tmo_cnt           <= '0;
      arb__fsm__req_vld <= 1'b0;
      arb__fsm__addr    <= '0;
      arb__fsm__wr_en   <= 1'b0;
      arb__fsm__rd_en   <= 1'b0;
      arb__fsm__wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|mst__arb__req_vld) begin
            state             <= BUSY;
            arb__grant        <= win;
            tmo_cnt           <= '0;
            arb__fsm__req_vld <= 1'b1;
            arb__fsm__addr    <= mst__arb__addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            arb__fsm__wr_en   <= mst__arb__wr_en[win];
            arb__fsm__rd_en   <= mst__arb__rd_en[win];
            arb__fsm__wr_data <= mst__arb__wr_data[win*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        BUSY: begin
          if (ack_hit || tmo_hit) begin
            state             <= IDLE;
            rr_ptr            <= nxt_ptr;
            arb__fsm__req_vld <= 1'b0;
            arb__fsm__addr    <= '0;
            arb__fsm__wr_en   <= 1'b0;
            arb__fsm__rd_en   <= 1'b0;
            arb__fsm__wr_data <= '0;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_mst_arbiter.sv
`timescale 1ns/1ps
module tb_reg_mst_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam int GW = $clog2(N);
  localparam logic [DW-1:0] ERRD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req, wr, rd;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  ack, err;
  logic [DW-1:0] rdata;
  logic          srst_in = 1'b0;
  logic          f_req, f_wr, f_rd, f_srst;
  logic          f_ack = 1'b0;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata;
  logic [DW-1:0] f_rdata = '0;
  logic [GW-1:0] gnt;

  always #5 clk = ~clk;

  reg_mst_arbiter #(.N_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rstn(rstn),
    .mst__arb__req_vld(req), .mst__arb__addr(addr), .mst__arb__wr_en(wr),
    .mst__arb__rd_en(rd), .mst__arb__wr_data(wdata),
    .arb__mst__ack_vld(ack), .arb__mst__rd_data(rdata), .arb__mst__err(err),
    .mst__arb__sync_reset(srst_in),
    .arb__fsm__req_vld(f_req), .arb__fsm__addr(f_addr), .arb__fsm__wr_en(f_wr),
    .arb__fsm__rd_en(f_rd), .arb__fsm__wr_data(f_wdata),
    .fsm__arb__ack_vld(f_ack), .fsm__arb__rd_data(f_rdata),
    .arb__fsm__sync_reset(f_srst), .arb__grant(gnt)
  );

  // ---------------- scoreboard state ----------------
  typedef struct { logic [AW-1:0] a; logic w; logic r; logic [DW-1:0] d; int g; } fexp_t;
  typedef struct { logic [N-1:0] v; logic [DW-1:0] d; logic e; } mexp_t;
  fexp_t fq[$];
  mexp_t mq[$];
  int    gseq[$];
  int    n_tests = 0, n_fail = 0, n_acks = 0, n_srst = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, modulo N.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- master-side stimulus ----------------
  logic [N-1:0]  m_req = '0, m_wr = '0, m_rd = '0;
  logic [AW-1:0] m_addr[N];
  logic [DW-1:0] m_data[N];
  bit            rand_en = 0, renew = 0;
  logic [N-1:0]  ack_seen;

  function automatic void new_req(input int i);
    m_req[i]  = 1'b1;
    m_addr[i] = {$urandom, $urandom};
    m_data[i] = $urandom;
    m_wr[i]   = 1'($urandom_range(0, 1));
    m_rd[i]   = ~m_wr[i];
  endfunction

  // Masters hold their request until their own ack, then drop or renew.
  initial begin
    req = '0; wr = '0; rd = '0; addr = '0; wdata = '0;
    forever begin
      @(negedge clk);
      ack_seen = ack;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (ack_seen[i]) begin
          if (renew || (rand_en && $urandom_range(0, 1) == 1)) new_req(i);
          else m_req[i] = 1'b0;
        end else if (rand_en && !m_req[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
        addr[i*AW +: AW]  = m_addr[i];
        wdata[i*DW +: DW] = m_data[i];
      end
      req = m_req; wr = m_wr; rd = m_rd;
    end
  end

  // ---------------- downstream FSM model + expectation generator ----------------
  int   ptr = 0, bcyc = 0, plan = 1, cur_w = 0;
  bit   plan_rand = 0, force_d = 0;
  logic [DW-1:0] fdata = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      f_ack = 1'b0;
      if (!rstn || srst_in) begin
        ptr = 0; bcyc = 0;
      end else if (!f_req) begin
        bcyc = 0;
        // Acks while idle must be ignored by the arbiter.
        if (rand_en && $urandom_range(0, 7) == 0) begin f_ack = 1'b1; f_rdata = $urandom; end
      end else begin
        bcyc++;
        if (bcyc == 1) begin
          cur_w = pick(req, ptr);
          if (cur_w < 0) begin chk("grant_without_request", 1, 0); cur_w = 0; end
          if (plan_rand) plan = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 11);
          fq.push_back('{addr[cur_w*AW +: AW], wr[cur_w], rd[cur_w], wdata[cur_w*DW +: DW], cur_w});
        end
        if (plan != 0 && bcyc == plan && plan <= T) begin
          f_ack   = 1'b1;
          f_rdata = force_d ? fdata : $urandom;
          mq.push_back('{N'(1) << cur_w, f_rdata, 1'b0});
          ptr = (cur_w + 1) % N;
        end else if (bcyc == T) begin
          mq.push_back('{N'(1) << cur_w, ERRD, 1'b1});
          ptr = (cur_w + 1) % N;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  fexp_t cur_f;
  bit    prev_req = 0;
  initial begin
    cur_f = '{'0, 1'b0, 1'b0, '0, 0};
    forever begin
      logic  exp_sr;
      mexp_t m;
      @(negedge clk);
      if (!rstn) begin prev_req = 0; continue; end
      if (f_req && !prev_req) begin
        chk("fsm_req_expected", fq.size() > 0, 1);
        if (fq.size() > 0) begin
          cur_f = fq.pop_front();
          chk("grant_index", gnt, cur_f.g);
          gseq.push_back(int'(gnt));
        end
      end
      if (f_req) begin
        chk("fsm_addr", f_addr, cur_f.a);
        chk("fsm_wr_rd", {f_wr, f_rd}, {cur_f.w, cur_f.r});
        chk("fsm_wdata", f_wdata, cur_f.d);
      end else begin
        chk("fsm_idle_payload", {f_wr, f_rd, f_addr[31:0] | f_addr[63:32] | f_wdata}, 0);
      end
      exp_sr = srst_in;
      chk("mst_ack_when_due", (|ack) || (|err), mq.size() > 0);
      if (mq.size() > 0) begin
        m = mq.pop_front();
        n_acks++;
        chk("mst_ack_vec", ack, m.v);
        chk("mst_err_vec", err, m.e ? m.v : '0);
        chk("mst_rd_data", rdata, m.d);
        exp_sr = exp_sr | m.e;
      end else begin
        chk("rd_data_idle", rdata, 0);
      end
      chk("fsm_sync_reset", f_srst, exp_sr);
      if (f_srst && !srst_in) n_srst++;
      prev_req = f_req;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_acks(input int target, input int budget, input string nm);
    int c = 0;
    while (n_acks < target && c < budget) begin @(negedge clk); c++; end
    chk(nm, n_acks >= target, 1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int c = 0;
    while ((|m_req || f_req) && c < budget) begin @(negedge clk); c++; end
    chk(nm, (|m_req) || f_req, 0);
  endtask

  task automatic wait_busy(input int budget, input string nm);
    int c = 0;
    while (!f_req && c < budget) begin @(negedge clk); c++; end
    chk(nm, f_req, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int a0, gs, s0;
    for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_fsm_req", f_req, 0);
    chk("rst_fsm_payload", {f_wr, f_rd, f_addr[31:0] | f_addr[63:32] | f_wdata}, 0);
    chk("rst_mst_out", {ack, err, rdata}, 0);
    chk("rst_sync_grant", {f_srst, gnt}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single read by master 1, acked on the 4th BUSY cycle.
    plan = 4; force_d = 1; fdata = 32'h1234_5678;
    m_addr[1] = 64'h40; m_rd[1] = 1'b1; m_wr[1] = 1'b0; m_data[1] = '0; m_req[1] = 1'b1;
    @(negedge clk);
    chk("latency_not_before_sample", f_req, 0);
    @(negedge clk);
    chk("latency_k_plus_1", f_req, 1);
    wait_acks(1, 40, "single_read_done");
    force_d = 0;
    wait_idle(20, "single_read_idle");

    // Contention from pointer 0: master 0 first, then master 1.
    plan = 2;
    m_addr[0] = 64'h10; m_data[0] = 32'hA; m_wr[0] = 1'b1; m_rd[0] = 1'b0; m_req[0] = 1'b1;
    m_addr[1] = 64'h20; m_data[1] = 32'hB; m_wr[1] = 1'b1; m_rd[1] = 1'b0; m_req[1] = 1'b1;
    wait_acks(3, 60, "contention_done");
    wait_idle(20, "contention_idle");

    // Rotation with both masters requesting continuously.
    a0 = n_acks; gs = gseq.size();
    renew = 1; new_req(0); new_req(1);
    wait_acks(a0 + 6, 200, "rotation_done");
    renew = 0;
    wait_idle(60, "rotation_idle");
    for (int k = 0; k < 6; k++)
      chk("rotation_grant", (gseq.size() > gs + k) ? gseq[gs + k] : -1, k % 2);

    // Watchdog expiry: FSM never acks.
    plan = 0; s0 = n_srst; a0 = n_acks;
    new_req(0);
    wait_acks(a0 + 1, 40, "timeout_done");
    wait_idle(20, "timeout_idle");
    chk("timeout_sync_pulses", n_srst - s0, 1);

    // Ack exactly on the timeout cycle wins over the watchdog.
    plan = T; s0 = n_srst; a0 = n_acks;
    new_req(1);
    wait_acks(a0 + 1, 40, "boundary_done");
    wait_idle(20, "boundary_idle");
    chk("boundary_no_sync_pulse", n_srst - s0, 0);

    // Soft reset mid-BUSY: leave ptr at 1, then drop master 1's transaction.
    plan = 2; a0 = n_acks;
    new_req(0);
    wait_acks(a0 + 1, 40, "srst_setup_done");
    wait_idle(20, "srst_setup_idle");
    plan = 0; a0 = n_acks;
    new_req(1);
    wait_busy(20, "srst_busy");
    repeat (2) @(negedge clk);
    srst_in = 1'b1;
    new_req(0);
    @(negedge clk);
    chk("srst_req_drop", f_req, 0);
    chk("srst_no_ack", n_acks, a0);
    @(negedge clk);
    plan = 2; gs = gseq.size();
    srst_in = 1'b0;
    wait_acks(a0 + 2, 60, "srst_recover_done");
    chk("srst_ptr_zero", (gseq.size() > gs) ? gseq[gs] : -1, 0);
    wait_idle(20, "srst_idle");

    // Randomized traffic, random ack delays including timeouts and idle acks.
    plan_rand = 1; rand_en = 1;
    repeat (1500) @(negedge clk);
    rand_en = 0;
    wait_idle(400, "random_drain");
    plan_rand = 0;

    // Asynchronous reset in the middle of BUSY.
    plan = 0;
    new_req(1);
    wait_busy(20, "arst_busy");
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_fsm_req", f_req, 0);
    chk("arst_fsm_payload", {f_wr, f_rd, f_addr[31:0] | f_addr[63:32] | f_wdata}, 0);
    chk("arst_mst_out", {ack, err, rdata}, 0);
    chk("arst_sync_grant", {f_srst, gnt}, 0);
    m_req = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("fsm_queue_empty", fq.size(), 0);
    chk("mst_queue_empty", mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule
